// File: rtl/demux_1to2_8bits_if.sv
// Bus bundle for the 1:2 de-interleaving demux. The master side feeds words
// and pop requests. The slave side (the demux) returns lane data and status.
interface demux_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out0;
    logic              valid_out1;
    logic              empty0;
    logic              empty1;
    logic              full0;
    logic              full1;
    logic              pause;
    logic              sel_state;
    logic              underflow_err;

    modport master (
        output data_in, valid_in, pop0, pop1,
        input  data_out0, data_out1, valid_out0, valid_out1,
        input  empty0, empty1, full0, full1, pause, sel_state, underflow_err
    );

    modport slave (
        input  data_in, valid_in, pop0, pop1,
        output data_out0, data_out1, valid_out0, valid_out1,
        output empty0, empty1, full0, full1, pause, sel_state, underflow_err
    );
endinterface

// File: rtl/demux_1to2_8bits.sv
// 1:2 demux that undoes an alternating 2:1 interleave. Accepted words go to
// lane 0, lane 1, lane 0, and so on. Each lane is a DEPTH-entry FIFO with a
// registered read port. DEPTH must be a power of two and at least 2, so that
// the pointers wrap for free.
module demux_1to2_8bits #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic   clk,
    input  logic   reset_L,
    demux_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic              sel_state;
    logic              sel_next;
    logic              pause;
    logic              accept;
    logic [1:0]        push;
    logic [1:0]        pop_req;
    logic [1:0]        pop_ok;
    logic [1:0]        empty;
    logic [1:0]        full;
    logic              underflow_err;

    logic [PW-1:0]     wr_ptr   [2];
    logic [PW-1:0]     rd_ptr   [2];
    logic [CW-1:0]     count    [2];
    logic [DATA_W-1:0] data_out [2];
    logic [1:0]        valid_out;
    logic [DATA_W-1:0] mem      [2][DEPTH];

    // Lane status comes only from registered counts; a same-cycle pop never frees a slot early
    always_comb begin
        pop_req = {bus.pop1, bus.pop0};
        empty   = 2'b00;
        full    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (count[i] == '0);
            full[i]  = (count[i] == CNT_FULL);
        end
        pause  = sel_state ? full[1] : full[0];
        accept = bus.valid_in & ~pause;
        push   = accept ? (sel_state ? 2'b10 : 2'b01) : 2'b00;
        // No fall-through: a pop on an empty lane is dropped even if that lane is pushed now
        pop_ok = pop_req & ~empty;
    end

    // Lane selector state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) sel_state <= 1'b0;
        else          sel_state <= sel_next;
    end

    // Lane selector next state: toggle only on an accepted word
    always_comb begin
        sel_next = sel_state;
        if (accept) sel_next = ~sel_state;
    end

    // FIFO bookkeeping, registered read port and sticky underflow flag
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                count[i]    <= '0;
                data_out[i] <= '0;
            end
            valid_out     <= 2'b00;
            underflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop_ok[i]) begin
                    rd_ptr[i]   <= rd_ptr[i] + PW'(1);
                    data_out[i] <= mem[i][rd_ptr[i]];
                end
                case ({push[i], pop_ok[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
            valid_out <= pop_ok;
            if (|(pop_req & empty)) underflow_err <= 1'b1;
        end
    end

    // Lane storage; unreset because a slot is only read after it has been written
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.data_in;
        end
    end

    assign bus.data_out0     = data_out[0];
    assign bus.data_out1     = data_out[1];
    assign bus.valid_out0    = valid_out[0];
    assign bus.valid_out1    = valid_out[1];
    assign bus.empty0        = empty[0];
    assign bus.empty1        = empty[1];
    assign bus.full0         = full[0];
    assign bus.full1         = full[1];
    assign bus.pause         = pause;
    assign bus.sel_state     = sel_state;
    assign bus.underflow_err = underflow_err;
endmodule

// File: tb/tb_demux_1to2_8bits.sv
// Directed bench for demux_1to2_8bits with hand-computed expected values.
module tb_demux_1to2_8bits;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset_L;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    demux_if #(.DATA_W(DATA_W)) bus ();

    demux_1to2_8bits #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic p0, input logic p1);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.pop0     = p0;
        bus.pop1     = p1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called between edges: a short reset pulse that never spans a clock edge
    task automatic reset_pulse();
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
        drive(0, 8'h00, 0, 0);
    endtask

    logic [7:0] exp0 [4];
    logic [7:0] exp1 [4];

    initial begin
        reset_L = 1'b1;
        drive(0, 8'h00, 0, 0);
        #1 reset_L = 1'b0;
        #1;
        check("rst_sel", bus.sel_state, 0);
        check("rst_dout0", bus.data_out0, 0);
        check("rst_dout1", bus.data_out1, 0);
        check("rst_vld", {bus.valid_out1, bus.valid_out0}, 0);
        check("rst_empty", {bus.empty1, bus.empty0}, 2'b11);
        check("rst_full", {bus.full1, bus.full0}, 0);
        check("rst_uflow", bus.underflow_err, 0);
        check("rst_pause", bus.pause, 0);
        #1 reset_L = 1'b1;

        // Basic split
        drive(1, 8'hA1, 0, 0); tick(); check("split_sel1", bus.sel_state, 1);
        drive(1, 8'hB2, 0, 0); tick(); check("split_sel2", bus.sel_state, 0);
        drive(1, 8'hC3, 0, 0); tick(); check("split_sel3", bus.sel_state, 1);
        drive(1, 8'hD4, 0, 0); tick(); check("split_sel4", bus.sel_state, 0);
        drive(0, 8'h00, 1, 1); tick();
        check("split_o0a", bus.data_out0, 8'hA1);
        check("split_o1a", bus.data_out1, 8'hB2);
        check("split_v", {bus.valid_out1, bus.valid_out0}, 2'b11);
        tick();
        check("split_o0b", bus.data_out0, 8'hC3);
        check("split_o1b", bus.data_out1, 8'hD4);
        drive(0, 8'h00, 0, 0); tick();
        check("split_idle_v", {bus.valid_out1, bus.valid_out0}, 0);
        check("split_hold", bus.data_out1, 8'hD4);
        check("split_empty", {bus.empty1, bus.empty0}, 2'b11);

        // Backpressure
        reset_pulse();
        for (int k = 1; k <= 8; k++) begin
            drive(1, 8'(k), 0, 0);
            tick();
        end
        check("bp_full", {bus.full1, bus.full0}, 2'b11);
        check("bp_sel", bus.sel_state, 0);
        drive(1, 8'h09, 0, 0);
        check("bp_pause", bus.pause, 1);
        tick();
        check("bp_hold_sel", bus.sel_state, 0);
        check("bp_hold_full", bus.full0, 1);
        drive(1, 8'h09, 1, 0);
        check("bp_pause_pop", bus.pause, 1);
        tick();
        check("bp_pop_d", bus.data_out0, 8'h01);
        check("bp_pop_v", bus.valid_out0, 1);
        check("bp_nfull", bus.full0, 0);
        check("bp_sel_held", bus.sel_state, 0);
        check("bp_pause0", bus.pause, 0);
        drive(1, 8'h09, 0, 0); tick();
        check("bp_acc_sel", bus.sel_state, 1);
        check("bp_refull", bus.full0, 1);
        exp0 = '{8'h03, 8'h05, 8'h07, 8'h09};
        exp1 = '{8'h02, 8'h04, 8'h06, 8'h08};
        drive(0, 8'h00, 1, 1);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("bp_drain0", bus.data_out0, exp0[j]);
            check("bp_drain1", bus.data_out1, exp1[j]);
        end
        check("bp_empty", {bus.empty1, bus.empty0}, 2'b11);

        // Same-lane push and pop
        reset_pulse();
        drive(1, 8'h11, 0, 0); tick();
        drive(1, 8'h22, 0, 0); tick();
        drive(1, 8'h33, 0, 0); tick();
        drive(1, 8'h44, 0, 0); tick();
        check("pp_sel", bus.sel_state, 0);
        drive(1, 8'h55, 1, 0); tick();
        check("pp_d", bus.data_out0, 8'h11);
        check("pp_v", bus.valid_out0, 1);
        check("pp_sel2", bus.sel_state, 1);
        drive(0, 8'h00, 1, 0); tick();
        check("pp_d2", bus.data_out0, 8'h33);
        check("pp_ne", bus.empty0, 0);
        tick();
        check("pp_d3", bus.data_out0, 8'h55);
        check("pp_e", bus.empty0, 1);

        // Underflow
        reset_pulse();
        drive(1, 8'h66, 0, 0); tick();
        drive(1, 8'h77, 0, 1);
        check("uf_pause", bus.pause, 0);
        tick();
        check("uf_v", bus.valid_out1, 0);
        check("uf_d", bus.data_out1, 0);
        check("uf_flag", bus.underflow_err, 1);
        check("uf_ne", bus.empty1, 0);
        drive(0, 8'h00, 0, 1); tick();
        check("uf_d2", bus.data_out1, 8'h77);
        check("uf_v2", bus.valid_out1, 1);
        check("uf_sticky", bus.underflow_err, 1);

        // Wrap-around, starting from pointers offset by one
        reset_pulse();
        drive(1, 8'hF0, 0, 0); tick();
        drive(1, 8'hF1, 0, 0); tick();
        drive(0, 8'h00, 1, 1); tick();
        check("wr_pre0", bus.data_out0, 8'hF0);
        check("wr_pre1", bus.data_out1, 8'hF1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                drive(1, 8'(8'h10 + r * 8 + i), 0, 0);
                tick();
                check("wr_full0", bus.full0, (i >= 6) ? 1 : 0);
                check("wr_full1", bus.full1, (i == 7) ? 1 : 0);
                check("wr_empty1", bus.empty1, (i == 0) ? 1 : 0);
            end
            for (int j = 0; j < 4; j++) begin
                drive(0, 8'h00, 1, 1);
                tick();
                check("wr_d0", bus.data_out0, 8'h10 + r * 8 + 2 * j);
                check("wr_d1", bus.data_out1, 8'h10 + r * 8 + 2 * j + 1);
                check("wr_empty", {bus.empty1, bus.empty0}, (j == 3) ? 2'b11 : 2'b00);
                check("wr_nfull", {bus.full1, bus.full0}, 0);
            end
        end
        check("wr_uflow", bus.underflow_err, 0);

        // Async reset mid-stream
        reset_pulse();
        drive(0, 8'h00, 0, 1); tick();
        check("ar_uf", bus.underflow_err, 1);
        drive(1, 8'h01, 0, 0); tick();
        drive(1, 8'h02, 0, 0); tick();
        drive(1, 8'h03, 1, 1); tick();
        check("ar_pre_v", {bus.valid_out1, bus.valid_out0}, 2'b11);
        check("ar_pre_sel", bus.sel_state, 1);
        drive(0, 8'h00, 0, 0);
        #2 reset_L = 1'b0;
        #1;
        check("ar_sel", bus.sel_state, 0);
        check("ar_d0", bus.data_out0, 0);
        check("ar_d1", bus.data_out1, 0);
        check("ar_v", {bus.valid_out1, bus.valid_out0}, 0);
        check("ar_empty", {bus.empty1, bus.empty0}, 2'b11);
        check("ar_full", {bus.full1, bus.full0}, 0);
        check("ar_uf0", bus.underflow_err, 0);
        reset_L = 1'b1;
        drive(1, 8'hEE, 0, 0); tick();
        check("ar_post_sel", bus.sel_state, 1);
        check("ar_post_e", {bus.empty1, bus.empty0}, 2'b10);
        drive(0, 8'h00, 1, 1); tick();
        check("ar_post_d", bus.data_out0, 8'hEE);
        check("ar_post_v", {bus.valid_out1, bus.valid_out0}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/demux_1to2_8bits.md
DEMUX_1TO2_8BITS -- requirements
Module: demux_1to2_8bits

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of data words.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the entries per lane FIFO; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_L  input  1  reset, asynchronous and active-low.
REQ-005 data_in  input  DATA_W  incoming interleaved word.
REQ-006 valid_in  input  1  data_in holds a word to deliver.
REQ-007 pop0, pop1  input  1 each  request to read the head of lane 0 or lane 1.
REQ-008 data_out0, data_out1  output  DATA_W each  registered lane outputs.
REQ-009 valid_out0, valid_out1  output  1 each  the matching data_outN was updated on the last edge.
REQ-010 empty0, empty1, full0, full1  output  1 each  lane FIFO status.
REQ-011 pause  output  1  combinational; high means the word on data_in is not accepted this cycle.
REQ-012 sel_state  output  1  the lane that receives the next accepted word.
REQ-013 underflow_err  output  1  sticky flag for a pop issued on an empty lane.

Function
REQ-014 The block SHALL undo the alternating interleave of the 2:1 mux: accepted words go to lane 0, lane 1, lane 0, and so on, starting at lane 0.
REQ-015 pause SHALL equal full of the lane selected by sel_state, regardless of pop on that lane in the same cycle.
REQ-016 A word is accepted when valid_in=1 and pause=0; on that edge it SHALL be written to the tail of the selected lane, and sel_state SHALL toggle.
REQ-017 When valid_in=1 and pause=1, no write SHALL occur and sel_state SHALL hold; upstream holds the word until it is accepted.
REQ-018 When valid_in=0, sel_state and both FIFOs' write sides SHALL hold.
REQ-019 Each lane SHALL be a FIFO: write and read pointers wrap modulo DEPTH, and an occupancy count has range 0..DEPTH.
REQ-020 emptyN SHALL equal (countN==0), and fullN SHALL equal (countN==DEPTH); both are registered-state derived and carry no bypass.
REQ-021 On an edge with popN=1 and emptyN=0, the block SHALL load the head into data_outN, set valid_outN=1, and advance the read pointer.
REQ-022 On any other edge, valid_outN SHALL be 0 and data_outN SHALL hold its last value.
REQ-023 A simultaneous accepted push and valid pop on the same lane SHALL leave countN unchanged, with both pointers advancing.
REQ-024 A pop on an empty lane SHALL be ignored, even with a same-cycle push to that lane (no fall-through), and SHALL set underflow_err=1.
REQ-025 Minimum latency SHALL be 2 edges: a word accepted at edge k can be popped at edge k+1, so valid_outN is high after edge k+1.
REQ-026 The two lanes SHALL operate independently; pops on both lanes in one cycle are both served.

Reset
REQ-027 While reset_L=0, immediately and independent of clk, the block SHALL set:
- sel_state=0
- all pointers and counts=0
- data_out0 and data_out1=0
- valid_out0 and valid_out1=0
- empty0 and empty1=1
- full0 and full1=0
- underflow_err=0
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; the first word accepted after release SHALL go to lane 0.
REQ-029 FIFO storage contents need not be reset, but SHALL never be observable until they are written.

Verification
REQ-030 Basic split: after reset, push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles, then pop0 and pop1 twice each -> lane 0 outputs 0xA1 then 0xC3, lane 1 outputs 0xB2 then 0xD4, with sel_state alternating 0,1,0,1,0.
REQ-031 Backpressure: push 9 words (0x01..0x09) with no pops, DEPTH=4 -> full0=full1=1 after 8 words; pause=1 with sel_state=0 while 0x09 is held; pop0 one cycle -> 0x09 accepted the next cycle into lane 0.
REQ-032 Same-lane push and pop: lane 0 holds 2 words and lane 0 is selected; push 0x55 while pop0=1 -> count0 stays 2, data_out0 = the oldest word, and 0x55 is later read in order.
REQ-033 Underflow: pop1=1 on an empty lane 1 while 0x77 is pushed to lane 1 -> valid_out1=0, underflow_err=1, and the next pop1 returns 0x77.
REQ-034 Wrap-around: 3 full fill-and-drain cycles per lane with the pattern 0x10+i -> order is preserved across pointer wrap, and empty/full are correct at every boundary.
REQ-035 Async reset: assert reset_L mid-stream between clock edges -> all outputs take their reset values before the next edge; post-release word 0xEE appears on lane 0.
